gather_arbiter: RTL and testbench

Front-end arbiter that shares the slot lanes of the vector gather stage among `REQUESTERS` independent producers. Each producer presents one element tagged with a destination slot. Per slot, the block picks one winner per cycle by round-robin and registers it onto that slot's lane toward the gatherer. It never issues into a slot the gatherer already holds, and never issues on the cycle a completed vector is shifted out.

---
 rtl/gather_arbiter_if.sv | 39 +++
 rtl/gather_arbiter.sv | 106 ++++++++++
 tb/tb_gather_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/gather_arbiter_if.sv
// gather_arbiter_if
// Bundles the producer request bus, the per-slot lanes toward the gatherer,
// and the gatherer status/feedback signals used by gather_arbiter.
//   req_valid/req_ready/req_data/req_slot : one element per producer
//   out_valid/out_data/out_ready          : one lane per vector slot
//   slot_filled/vec_done                  : gatherer occupancy and shift-out
//   vec_count/err_slot                    : status back to the system
// modport master : the arbiter side (drives req_ready and the lanes)
// modport slave  : the producer/gatherer environment side
interface gather_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int REQUESTERS = 4,
   parameter int SLOTS      = 3,
   parameter int CNT_W      = 16
);
   localparam int SLOT_W = $clog2(SLOTS);

   logic [REQUESTERS-1:0]                 req_valid;
   logic [REQUESTERS-1:0]                 req_ready;
   logic [REQUESTERS-1:0][DATA_WIDTH-1:0] req_data;
   logic [REQUESTERS-1:0][SLOT_W-1:0]     req_slot;
   logic [SLOTS-1:0]                      out_valid;
   logic [SLOTS-1:0][DATA_WIDTH-1:0]      out_data;
   logic                                  out_ready;
   logic [SLOTS-1:0]                      slot_filled;
   logic                                  vec_done;
   logic [CNT_W-1:0]                      vec_count;
   logic                                  err_slot;

   modport master (
      input  req_valid, req_data, req_slot, out_ready, slot_filled, vec_done,
      output req_ready, out_valid, out_data, vec_count, err_slot
   );

   modport slave (
      output req_valid, req_data, req_slot, out_ready, slot_filled, vec_done,
      input  req_ready, out_valid, out_data, vec_count, err_slot
   );
endinterface

// File: rtl/gather_arbiter.sv
// gather_arbiter
// Shares the slot lanes of the vector gather stage among REQUESTERS producers.
// Each slot runs its own round-robin pick among the producers targeting it and
// registers the winner onto that slot's lane. A slot is never issued into while
// its lane is still pending, while the gatherer already holds it, or on the
// cycle a completed vector is shifted out.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : gather_arbiter_if.master (request bus, lanes, gatherer status)
module gather_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int REQUESTERS = 4,
   parameter int SLOTS      = 3,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gather_arbiter_if.master      bus
);
   localparam int SLOT_W = $clog2(SLOTS);
   localparam int PTR_W  = $clog2(REQUESTERS);

   logic [SLOTS-1:0]                 r_out_valid;
   logic [SLOTS-1:0][DATA_WIDTH-1:0] r_out_data;
   logic [SLOTS-1:0][PTR_W-1:0]      r_rr_ptr;
   logic [CNT_W-1:0]                 r_vec_count;
   logic                             r_err_slot;

   logic [SLOTS-1:0]                 w_elig;
   logic [SLOTS-1:0]                 w_grant;
   logic [SLOTS-1:0][PTR_W-1:0]      w_win;
   logic [REQUESTERS-1:0]            w_ready;
   logic                             w_oor;
   logic [PTR_W-1:0]                 w_idx;

   always_comb begin
      w_elig  = '0;
      w_grant = '0;
      w_win   = '0;
      w_ready = '0;
      w_oor   = 1'b0;
      w_idx   = '0;
      for (int s = 0; s < SLOTS; s++) begin
         w_elig[s] = !r_out_valid[s] && !bus.slot_filled[s] && !bus.vec_done && rst_n;
         // Cyclic scan starting at this slot's pointer; first hit wins.
         for (int k = 0; k < REQUESTERS; k++) begin
            w_idx = PTR_W'((int'(r_rr_ptr[s]) + k) % REQUESTERS);
            if (!w_grant[s] && w_elig[s] && bus.req_valid[w_idx] &&
                bus.req_slot[w_idx] == SLOT_W'(s)) begin
               w_grant[s] = 1'b1;
               w_win[s]   = w_idx;
            end
         end
         if (w_grant[s]) begin
            w_ready[w_win[s]] = 1'b1;
         end
      end
      // Elements aimed past the last slot are swallowed so the producer
      // cannot stall forever; the error flag records that it happened.
      for (int r = 0; r < REQUESTERS; r++) begin
         if (bus.req_valid[r] && int'(bus.req_slot[r]) >= SLOTS) begin
            w_ready[r] = 1'b1;
            w_oor      = 1'b1;
         end
      end
      if (!rst_n) begin
         w_ready = '0;
         w_oor   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= '0;
         r_out_data  <= '0;
         r_rr_ptr    <= '0;
         r_vec_count <= '0;
         r_err_slot  <= 1'b0;
      end else begin
         for (int s = 0; s < SLOTS; s++) begin
            // A grant needs an empty lane, so issue and accept never collide.
            if (w_grant[s]) begin
               r_out_valid[s] <= 1'b1;
               r_out_data[s]  <= bus.req_data[w_win[s]];
               r_rr_ptr[s]    <= (w_win[s] == PTR_W'(REQUESTERS-1)) ? '0 : w_win[s] + 1'b1;
            end else if (bus.out_ready) begin
               r_out_valid[s] <= 1'b0;
            end
         end
         if (bus.vec_done) begin
            r_vec_count <= r_vec_count + 1'b1;
         end
         if (w_oor) begin
            r_err_slot <= 1'b1;
         end
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.vec_count = r_vec_count;
   assign bus.err_slot  = r_err_slot;

endmodule

// File: tb/tb_gather_arbiter.sv
module tb_gather_arbiter;
   localparam int DW = 32;
   localparam int NR = 4;
   localparam int NS = 3;
   localparam int CW = 16;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   exp_vc = 0;
   int   rr_exp [5] = '{0, 1, 2, 3, 0};

   gather_arbiter_if #(.DATA_WIDTH(DW), .REQUESTERS(NR), .SLOTS(NS), .CNT_W(CW)) bus ();

   gather_arbiter #(.DATA_WIDTH(DW), .REQUESTERS(NR), .SLOTS(NS), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.req_valid   = '0;
      bus.req_data    = '0;
      bus.req_slot    = '0;
      bus.out_ready   = 1'b0;
      bus.slot_filled = '0;
      bus.vec_done    = 1'b0;

      // Reset with every producer requesting
      bus.req_valid   = 4'b1111;
      bus.req_slot[0] = 2'd0; bus.req_data[0] = 32'h11;
      bus.req_slot[1] = 2'd1; bus.req_data[1] = 32'h22;
      bus.req_slot[2] = 2'd2; bus.req_data[2] = 32'h33;
      bus.req_slot[3] = 2'd0; bus.req_data[3] = 32'h44;
      tick; tick;
      chk("rst_req_ready", bus.req_ready, 4'b0000);
      chk("rst_out_valid", bus.out_valid, 3'b000);
      chk("rst_vec_count", bus.vec_count, 16'd0);
      chk("rst_err_slot",  bus.err_slot, 1'b0);
      chk("rst_out_data0", bus.out_data[0], 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rel_grants", bus.req_ready, 4'b0111);
      tick;
      bus.req_valid = '0;
      #1;
      chk("rel_out_valid", bus.out_valid, 3'b111);
      chk("rel_data0", bus.out_data[0], 32'h11);
      chk("rel_data1", bus.out_data[1], 32'h22);
      chk("rel_data2", bus.out_data[2], 32'h33);
      chk("rel_ready_idle", bus.req_ready, 4'b0000);
      bus.out_ready = 1'b1;
      tick;
      chk("rel_accept", bus.out_valid, 3'b000);
      chk("rel_data_kept", bus.out_data[0], 32'h11);

      // Single issue: r0 -> slot 1
      bus.req_slot[0] = 2'd1; bus.req_data[0] = 32'hA5;
      bus.req_valid   = 4'b0001;
      #1;
      chk("single_ready", bus.req_ready, 4'b0001);
      tick;
      bus.req_valid = '0;
      #1;
      chk("single_valid_n1", bus.out_valid, 3'b010);
      chk("single_data_n1", bus.out_data[1], 32'hA5);
      tick;
      chk("single_valid_n2", bus.out_valid, 3'b000);

      // Reset pulse while idle: pointers back to 0
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      #1;

      // Round-robin on slot 0, gatherer slot cleared by vec_done each round
      for (int r = 0; r < NR; r++) begin
         bus.req_slot[r] = 2'd0;
         bus.req_data[r] = 32'h100 + r;
      end
      bus.req_valid = 4'b1111;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rr_grant%0d", i), bus.req_ready, 4'b0001 << rr_exp[i]);
         tick;
         chk($sformatf("rr_data%0d", i), bus.out_data[0], 32'h100 + rr_exp[i]);
         chk($sformatf("rr_hold%0d", i), bus.req_ready, 4'b0000);
         tick;
         bus.slot_filled[0] = 1'b1;
         #1;
         chk($sformatf("rr_filled%0d", i), bus.req_ready, 4'b0000);
         bus.vec_done = 1'b1;
         tick;
         exp_vc++;
         bus.vec_done       = 1'b0;
         bus.slot_filled[0] = 1'b0;
         #1;
      end
      bus.req_valid = '0;
      chk("rr_vec_count", bus.vec_count, 16'(exp_vc));

      // Occupancy / vec_done blocking
      bus.slot_filled[2] = 1'b1;
      bus.req_slot[1] = 2'd2; bus.req_data[1] = 32'h77;
      bus.req_valid   = 4'b0010;
      #1;
      chk("occ_blocked", bus.req_ready, 4'b0000);
      tick;
      chk("occ_no_lane", bus.out_valid, 3'b000);
      bus.slot_filled[2] = 1'b0;
      bus.vec_done       = 1'b1;
      #1;
      chk("done_blocked", bus.req_ready, 4'b0000);
      tick;
      exp_vc++;
      bus.vec_done = 1'b0;
      #1;
      chk("done_vec_count", bus.vec_count, 16'(exp_vc));
      chk("after_done_grant", bus.req_ready, 4'b0010);
      tick;
      bus.req_valid = '0;
      #1;
      chk("occ_lane_valid", bus.out_valid, 3'b100);
      chk("occ_lane_data", bus.out_data[2], 32'h77);
      tick;
      chk("occ_lane_clear", bus.out_valid, 3'b000);

      // Backpressure: slot 0 pointer is 1 after the round-robin wrap
      bus.out_ready   = 1'b0;
      bus.req_slot[1] = 2'd0; bus.req_data[1] = 32'hB1;
      bus.req_slot[2] = 2'd0; bus.req_data[2] = 32'hC2;
      bus.req_valid   = 4'b0110;
      #1;
      chk("bp_grant_r1", bus.req_ready, 4'b0010);
      tick;
      bus.req_valid = 4'b0100;
      #1;
      chk("bp_valid", bus.out_valid, 3'b001);
      chk("bp_r2_blocked", bus.req_ready, 4'b0000);
      tick; tick;
      chk("bp_valid_held", bus.out_valid, 3'b001);
      chk("bp_data_held", bus.out_data[0], 32'hB1);
      chk("bp_r2_still_blocked", bus.req_ready, 4'b0000);
      bus.out_ready = 1'b1;
      tick;
      bus.slot_filled[0] = 1'b1;
      #1;
      chk("bp_lane_cleared", bus.out_valid, 3'b000);
      chk("bp_filled_blocks", bus.req_ready, 4'b0000);
      tick;
      chk("bp_filled_blocks2", bus.req_ready, 4'b0000);
      bus.slot_filled[0] = 1'b0;
      #1;
      chk("bp_r2_granted", bus.req_ready, 4'b0100);
      tick;
      bus.req_valid = '0;
      #1;
      chk("bp_r2_data", bus.out_data[0], 32'hC2);
      tick;

      // Out-of-range slot
      bus.req_slot[3] = 2'd3; bus.req_data[3] = 32'hDD;
      bus.req_valid   = 4'b1000;
      #1;
      chk("oor_ready", bus.req_ready, 4'b1000);
      chk("oor_err_before", bus.err_slot, 1'b0);
      tick;
      bus.req_valid = '0;
      #1;
      chk("oor_err_set", bus.err_slot, 1'b1);
      chk("oor_no_lane", bus.out_valid, 3'b000);
      tick;
      chk("oor_err_sticky", bus.err_slot, 1'b1);

      // Reset mid-flight drops the pending lane; held request re-arbitrated
      bus.out_ready   = 1'b0;
      bus.req_slot[0] = 2'd2; bus.req_data[0] = 32'hEE;
      bus.req_valid   = 4'b0001;
      tick;
      chk("mid_lane_up", bus.out_valid, 3'b100);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_lane", bus.out_valid, 3'b000);
      chk("mid_rst_err", bus.err_slot, 1'b0);
      chk("mid_rst_count", bus.vec_count, 16'd0);
      chk("mid_rst_ready", bus.req_ready, 4'b0000);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_grant", bus.req_ready, 4'b0001);
      tick;
      bus.req_valid = '0;
      #1;
      chk("mid_rel_data", bus.out_data[2], 32'hEE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
